// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the instruction register / memory and the multicycle control FSM.
// Pure wiring, no latency; no flow control beyond mem_ready.
// master = control unit (drives selects/strobes), slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUCTL_W = 3
);
  logic [5:0]          Op;
  logic [5:0]          Funct;
  logic                mem_ready;
  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [1:0]          PCSrc;
  logic                Branch;
  logic                PCWrite;
  logic                illegal;
  logic [3:0]          state_o;

  modport master (
    input  Op, Funct, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, Branch, PCWrite, illegal, state_o
  );

  modport slave (
    output Op, Funct, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, Branch, PCWrite, illegal, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath (fetch/decode/execute/writeback, mul/div wait, trap).
// Latency: beq/j 3, R/sw/addi 4, lw 5, mul/div 4+MULDIV_LAT cycles with memory always ready.
// Backpressure: FETCH, MEMRD and MEMWR hold their state and outputs while mem_ready is low.
module multicycle_control_unit #(
  parameter int ALUCTL_W      = 3,
  parameter int MULDIV_LAT    = 4,
  parameter int ENABLE_JUMP   = 1,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_control_unit_if.master      bus
);
  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
                         S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
                         S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
                         S_MDWAIT = 4'd12, S_TRAP   = 4'd13;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000), ALU_OR  = ALUCTL_W'(3'b001),
                                  ALU_ADD = ALUCTL_W'(3'b010), ALU_MUL = ALUCTL_W'(3'b011),
                                  ALU_NOR = ALUCTL_W'(3'b100), ALU_DIV = ALUCTL_W'(3'b101),
                                  ALU_SUB = ALUCTL_W'(3'b110), ALU_SLT = ALUCTL_W'(3'b111);

  localparam int             CNT_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULDIV_LAT > 0) ? MULDIV_LAT - 1 : 0);

  logic [3:0]          state, next;
  logic [CNT_W-1:0]    md_cnt;
  logic                r_ok, r_md;
  logic [ALUCTL_W-1:0] r_alu;

  // Funct decode; anything unrecognised (or disabled) is flagged so DECODE traps instead of driving X
  always_comb begin
    r_ok  = 1'b1;
    r_md  = 1'b0;
    r_alu = ALU_ADD;
    case (bus.Funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b011000: begin r_alu = ALU_MUL; r_md = 1'b1; r_ok = (ENABLE_MULDIV != 0); end
      6'b011010: begin r_alu = ALU_DIV; r_md = 1'b1; r_ok = (ENABLE_MULDIV != 0); end
      default:   r_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      md_cnt <= '0;
    end else begin
      state <= next;
      if (state == S_EXEC && next == S_MDWAIT)
        md_cnt <= CNT_LOAD;
      else if (state == S_MDWAIT && md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_R:         next = r_ok ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: next = S_MEMADR;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = (ENABLE_JUMP != 0) ? S_JUMP : S_TRAP;
          default:      next = S_TRAP;
        endcase
      end
      S_MEMADR: next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next = S_FETCH;
      S_MEMWR:  next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next = (r_md && MULDIV_LAT > 0) ? S_MDWAIT : S_ALUWB;
      S_MDWAIT: next = (md_cnt == '0) ? S_ALUWB : S_MDWAIT;
      S_ALUWB:  next = S_FETCH;
      S_BRANCH: next = S_FETCH;
      S_ADDIEX: next = S_ADDIWB;
      S_ADDIWB: next = S_FETCH;
      S_JUMP:   next = S_FETCH;
      S_TRAP:   next = S_TRAP;
      default:  next = S_FETCH;
    endcase
  end

  // Strobes are qualified by rst_n so they drop the instant reset asserts
  always_comb begin
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_AND;
    bus.PCSrc      = 2'b00;
    bus.Branch     = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.illegal    = 1'b0;
    bus.state_o    = state;
    case (state)
      S_FETCH: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = ALU_ADD;
        bus.IRWrite    = bus.mem_ready & rst_n;
        bus.PCWrite    = bus.mem_ready & rst_n;
      end
      S_DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.ALUControl = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = ALU_ADD;
      end
      S_MEMRD: bus.IorD = 1'b1;
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = rst_n;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = rst_n;
      end
      S_EXEC, S_MDWAIT: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = r_alu;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = rst_n;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_SUB;
        bus.PCSrc      = 2'b01;
        bus.Branch     = rst_n;
      end
      S_ADDIWB: bus.RegWrite = rst_n;
      S_JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = rst_n;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for three control-unit builds (default, MULDIV_LAT=0, ENABLE_MULDIV=0) sharing one stimulus.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] op, funct;

  always #5 clk = ~clk;

  multicycle_control_unit_if if0 ();
  multicycle_control_unit_if if1 ();
  multicycle_control_unit_if if2 ();

  assign if0.Op = op;  assign if0.Funct = funct;  assign if0.mem_ready = mem_ready;
  assign if1.Op = op;  assign if1.Funct = funct;  assign if1.mem_ready = mem_ready;
  assign if2.Op = op;  assign if2.Funct = funct;  assign if2.mem_ready = mem_ready;

  multicycle_control_unit #(.ALUCTL_W(3), .MULDIV_LAT(4), .ENABLE_JUMP(1), .ENABLE_MULDIV(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  multicycle_control_unit #(.ALUCTL_W(3), .MULDIV_LAT(0), .ENABLE_JUMP(1), .ENABLE_MULDIV(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  multicycle_control_unit #(.ALUCTL_W(3), .MULDIV_LAT(4), .ENABLE_JUMP(1), .ENABLE_MULDIV(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,Branch,PCWrite,illegal}
  logic [16:0] obs [3];
  logic [3:0]  obs_st [3];
  assign obs[0] = {if0.IorD, if0.MemWrite, if0.IRWrite, if0.RegDst, if0.MemtoReg, if0.RegWrite, if0.ALUSrcA,
                   if0.ALUSrcB, if0.ALUControl, if0.PCSrc, if0.Branch, if0.PCWrite, if0.illegal};
  assign obs[1] = {if1.IorD, if1.MemWrite, if1.IRWrite, if1.RegDst, if1.MemtoReg, if1.RegWrite, if1.ALUSrcA,
                   if1.ALUSrcB, if1.ALUControl, if1.PCSrc, if1.Branch, if1.PCWrite, if1.illegal};
  assign obs[2] = {if2.IorD, if2.MemWrite, if2.IRWrite, if2.RegDst, if2.MemtoReg, if2.RegWrite, if2.ALUSrcA,
                   if2.ALUSrcB, if2.ALUControl, if2.PCSrc, if2.Branch, if2.PCWrite, if2.illegal};
  assign obs_st[0] = if0.state_o;
  assign obs_st[1] = if1.state_o;
  assign obs_st[2] = if2.state_o;

  typedef struct packed {
    logic [1:0]  dut;
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Expected control word for a state, straight from the state table
  function automatic logic [16:0] mk(input logic [3:0] st, input logic mr, input logic rv, input logic [2:0] ax);
    logic iord, mw, irw, rdst, m2r, rw, sa, br, pcw, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {iord, mw, irw, rdst, m2r, rw, sa, br, pcw, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      4'd0:        begin sb = 2'b01; alu = 3'b010; irw = mr & rv; pcw = mr & rv; end
      4'd1:        begin sb = 2'b11; alu = 3'b010; end
      4'd2, 4'd9:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
      4'd3:        iord = 1'b1;
      4'd4:        begin m2r = 1'b1; rw = rv; end
      4'd5:        begin iord = 1'b1; mw = rv; end
      4'd6, 4'd12: begin sa = 1'b1; alu = ax; end
      4'd7:        begin rdst = 1'b1; rw = rv; end
      4'd8:        begin sa = 1'b1; alu = 3'b110; ps = 2'b01; br = rv; end
      4'd10:       rw = rv;
      4'd11:       begin ps = 2'b10; pcw = rv; end
      4'd13:       ill = 1'b1;
      default:     ;
    endcase
    return {iord, mw, irw, rdst, m2r, rw, sa, sb, alu, ps, br, pcw, ill};
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (obs_st[e.dut] !== e.st) begin
        errors++;
        $display("FAIL dut%0d state at %0t: actual %0d required %0d", e.dut, $time, obs_st[e.dut], e.st);
      end
      checks++;
      if (obs[e.dut] !== e.o) begin
        errors++;
        $display("FAIL dut%0d outputs in state %0d at %0t: actual %b required %b",
                 e.dut, e.st, $time, obs[e.dut], e.o);
      end
    end
  end

  // One cycle of stimulus: drive inputs just after the edge and queue what each build must show this cycle
  task automatic step(input logic mr, input logic rv, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [2:0] ax);
    mem_ready = mr;
    rst_n     = rv;
    sbq.push_back('{dut: 2'd0, st: s0, o: mk(s0, mr, rv, ax)});
    sbq.push_back('{dut: 2'd1, st: s1, o: mk(s1, mr, rv, ax)});
    sbq.push_back('{dut: 2'd2, st: s2, o: mk(s2, mr, rv, ax)});
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = 6'd0; funct = 6'd0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 3'b000);

    // add: 0,1,6,7 with ALU add
    instr(6'b000000, 6'b100000);
    step(1, 1, 0, 0, 0, 3'b010); step(1, 1, 1, 1, 1, 3'b010);
    step(1, 1, 6, 6, 6, 3'b010); step(1, 1, 7, 7, 7, 3'b010);
    // sub and slt ALU codes
    instr(6'b000000, 6'b100010);
    step(1, 1, 0, 0, 0, 3'b110); step(1, 1, 1, 1, 1, 3'b110);
    step(1, 1, 6, 6, 6, 3'b110); step(1, 1, 7, 7, 7, 3'b110);
    instr(6'b000000, 6'b101010);
    step(1, 1, 0, 0, 0, 3'b111); step(1, 1, 1, 1, 1, 3'b111);
    step(1, 1, 6, 6, 6, 3'b111); step(1, 1, 7, 7, 7, 3'b111);
    // lw with two stalled cycles in MEMRD
    instr(6'b100011, 6'b000000);
    step(1, 1, 0, 0, 0, 3'b000); step(1, 1, 1, 1, 1, 3'b000); step(1, 1, 2, 2, 2, 3'b000);
    step(0, 1, 3, 3, 3, 3'b000); step(0, 1, 3, 3, 3, 3'b000); step(1, 1, 3, 3, 3, 3'b000);
    step(1, 1, 4, 4, 4, 3'b000);
    // sw with one stalled cycle in MEMWR, plus a stalled fetch
    instr(6'b101011, 6'b000000);
    step(0, 1, 0, 0, 0, 3'b000); step(1, 1, 0, 0, 0, 3'b000); step(1, 1, 1, 1, 1, 3'b000);
    step(1, 1, 2, 2, 2, 3'b000); step(0, 1, 5, 5, 5, 3'b000); step(1, 1, 5, 5, 5, 3'b000);
    // beq, j, addi
    instr(6'b000100, 6'b000000);
    step(1, 1, 0, 0, 0, 3'b000); step(1, 1, 1, 1, 1, 3'b000); step(1, 1, 8, 8, 8, 3'b000);
    instr(6'b000010, 6'b000000);
    step(1, 1, 0, 0, 0, 3'b000); step(1, 1, 1, 1, 1, 3'b000); step(1, 1, 11, 11, 11, 3'b000);
    instr(6'b001000, 6'b000000);
    step(1, 1, 0, 0, 0, 3'b000); step(1, 1, 1, 1, 1, 3'b000);
    step(1, 1, 9, 9, 9, 3'b000); step(1, 1, 10, 10, 10, 3'b000);

    // div: 4-cycle wait on dut0, direct writeback on dut1 (then stalled fetch), trap on dut2
    instr(6'b000000, 6'b011010);
    step(1, 1, 0, 0, 0, 3'b101);  step(1, 1, 1, 1, 1, 3'b101);
    step(1, 1, 6, 6, 13, 3'b101); step(1, 1, 12, 7, 13, 3'b101);
    step(0, 1, 12, 0, 13, 3'b101); step(0, 1, 12, 0, 13, 3'b101);
    step(0, 1, 12, 0, 13, 3'b101); step(0, 1, 7, 0, 13, 3'b101);

    // undefined opcode traps and the flag stays set
    instr(6'b111111, 6'b000000);
    step(1, 1, 0, 0, 13, 3'b000); step(1, 1, 1, 1, 13, 3'b000);
    for (int i = 0; i < 10; i++) step(1, 1, 13, 13, 13, 3'b000);
    step(1, 0, 0, 0, 0, 3'b000);

    // mul, reset asserted mid-MDWAIT, then fetch resumes
    instr(6'b000000, 6'b011000);
    step(1, 1, 0, 0, 0, 3'b011);  step(1, 1, 1, 1, 1, 3'b011);
    step(1, 1, 6, 6, 13, 3'b011); step(1, 1, 12, 7, 13, 3'b011);
    step(1, 0, 0, 0, 0, 3'b011);  step(1, 1, 0, 0, 0, 3'b011);
    step(1, 1, 1, 1, 1, 3'b011);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: actual %0d pending required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
